t1p_core_hs: RTL and testbench

//  Parametrised successor of the T1P 8-bit core: same byte-coded ISA (op=[4:0], reg=[7:5]), generic DATA_W/ADDR_W.

---
 rtl/t1p_pkg.sv | 50 +++++
 rtl/t1p_callstack.sv | 50 +++++
 rtl/t1p_core_hs.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_t1p_core_hs.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t1p_pkg.sv
// t1p_pkg: shared types and helpers for the T1P core family.
// Opcode and FSM state enums, flag bit positions, and the predicate that
// tells the fetcher whether an opcode carries a second (operand) byte.
package t1p_pkg;

  typedef enum logic [4:0] {
    OP_NOP     = 5'h00,
    OP_HLT     = 5'h01,
    OP_MOV_R_C = 5'h02,
    OP_MOV_R_M = 5'h03,
    OP_MOV_M_R = 5'h04,
    OP_MOV_R_R = 5'h05,
    OP_ADD_R_C = 5'h06,
    OP_ADD_R_R = 5'h07,
    OP_SUB_R_C = 5'h08,
    OP_SUB_R_R = 5'h09,
    OP_CMP_R_C = 5'h0A,
    OP_CMP_R_R = 5'h0B,
    OP_INC     = 5'h0C,
    OP_DEC     = 5'h0D,
    OP_JMP_C   = 5'h0E,
    OP_JF_C    = 5'h0F,
    OP_IN_R    = 5'h10,
    OP_OUT_R   = 5'h11,
    OP_CALL_C  = 5'h12,
    OP_RET     = 5'h13
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH_OP,
    ST_FETCH_D,
    ST_EXEC,
    ST_MEM,
    ST_IN_WAIT,
    ST_OUT_WAIT,
    ST_HALT
  } state_e;

  // Flag register bit positions.
  localparam int ZF = 0;
  localparam int AF = 1;
  localparam int CF = 2;

  // Two-byte instructions. CALL_C keeps its operand byte even when the
  // call stack is not built, so program layout does not depend on the build.
  function automatic logic has_operand(input logic [4:0] op);
    return (op >= 5'h02 && op <= 5'h0B) || op == 5'h0E || op == 5'h0F || op == 5'h12;
  endfunction

endpackage

// File: rtl/t1p_callstack.sv
// t1p_callstack: small LIFO holding return addresses for CALL_C/RET.
// Only instantiated when T1P_CALLSTACK_EN is defined. Push when full and
// pop when empty are ignored here; the core turns them into a fault.
module t1p_callstack #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] stack [DEPTH];
  logic [CW-1:0]     count;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = stack[IW'(count - CW'(1))];

  // Occupancy counter.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  // Entry storage.
  // NOTE: storage is not reset; the counter alone defines which entries are
  // valid, and leaving the array out of reset lets it map to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      stack[IW'(count)] <= push_data;
    end
  end

endmodule

// File: rtl/t1p_core_hs.sv
// t1p_core_hs: parametrised T1P core with req/ack memory bus and
// valid/ready I/O ports. Byte-coded ISA: op = ins[4:0], rd = ins[7:5].
// Build option: define T1P_CALLSTACK_EN to enable CALL_C/RET with a
// hardware return stack and the sticky err fault output.
module t1p_core_hs
  import t1p_pkg::*;
#(
  parameter int          DATA_W      = 8,
  parameter int          ADDR_W      = 16,
  parameter int unsigned RESET_IP    = 0,
  parameter int          STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted,
  output logic              err
);

  localparam logic [ADDR_W-1:0] IP_ONE = ADDR_W'(1);

  state_e            state;
  logic [7:0]        ins;
  logic [DATA_W-1:0] operand;
  logic [ADDR_W-1:0] ip;
  logic [DATA_W-1:0] rf [8];
  logic [2:0]        flags;

  opcode_e           op;
  logic [2:0]        rd;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] b_val;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] alu_res;
  logic              wr_res;
  logic [2:0]        flags_n;
  logic [3:0]        cond_vec;
  logic [ADDR_W-1:0] ea;
  logic [ADDR_W-1:0] next_ip;

  assign op       = opcode_e'(ins[4:0]);
  assign rd       = ins[7:5];
  assign rd_val   = rf[rd];
  assign ea       = ADDR_W'({rf[0], operand});
  assign sum      = {1'b0, rd_val} + {1'b0, b_val};
  assign diff     = {1'b0, rd_val} - {1'b0, b_val};
  assign cond_vec = {1'b1, flags[CF], flags[AF], flags[ZF]};

`ifdef T1P_CALLSTACK_EN
  logic              stk_push;
  logic              stk_pop;
  logic              stk_full;
  logic              stk_empty;
  logic [ADDR_W-1:0] stk_top;

  // ip already points past the operand byte, so it is the return address.
  assign stk_push = (state == ST_EXEC) && (op == OP_CALL_C) && !stk_full;
  assign stk_pop  = (state == ST_EXEC) && (op == OP_RET) && !stk_empty;

  t1p_callstack #(
    .DATA_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_callstack (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (ip),
    .pop_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );
`else
  assign err = 1'b0;
`endif

  // Second ALU operand: register for R_R forms, 1 for INC/DEC, else immediate.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    b_val = operand;
    case (op)
      OP_MOV_R_R, OP_ADD_R_R, OP_SUB_R_R, OP_CMP_R_R: b_val = rf[operand[2:0]];
      OP_INC, OP_DEC:                                 b_val = DATA_W'(1);
      default:                                        b_val = operand;
    endcase
  end

  // ALU result, register write-enable and flag update for the EXEC cycle.
  always_comb begin
    alu_res = rd_val;
    wr_res  = 1'b0;
    flags_n = flags;
    case (op)
      OP_MOV_R_C, OP_MOV_R_R: begin
        alu_res = b_val;
        wr_res  = 1'b1;
      end
      OP_ADD_R_C, OP_ADD_R_R, OP_INC: begin
        alu_res     = sum[DATA_W-1:0];
        wr_res      = 1'b1;
        flags_n[ZF] = (sum[DATA_W-1:0] == '0);
        flags_n[CF] = sum[DATA_W];
      end
      OP_SUB_R_C, OP_SUB_R_R, OP_DEC: begin
        alu_res     = diff[DATA_W-1:0];
        wr_res      = 1'b1;
        flags_n[ZF] = (diff[DATA_W-1:0] == '0);
        flags_n[CF] = diff[DATA_W];
      end
      OP_CMP_R_C, OP_CMP_R_R: begin
        flags_n[ZF] = (rd_val == b_val);
        flags_n[AF] = (rd_val > b_val);
        flags_n[CF] = (rd_val < b_val);
      end
      default: ;
    endcase
  end

  // Instruction pointer after EXEC: fall-through, jump target or return address.
  always_comb begin
    next_ip = ip;
    case (op)
      OP_JMP_C: next_ip = ea;
      OP_JF_C:  if (cond_vec[ins[6:5]] == ins[7]) next_ip = ea;
`ifdef T1P_CALLSTACK_EN
      OP_CALL_C: if (!stk_full) next_ip = ea;
      OP_RET:    if (!stk_empty) next_ip = stk_top;
`endif
      default: ;
    endcase
  end

  // Control FSM with registered bus and I/O outputs. Bus-using states re-arm
  // mem_req on exit so the next fetch starts without an idle cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_FETCH_OP;
      ip        <= ADDR_W'(RESET_IP);
      ins       <= '0;
      operand   <= '0;
      flags     <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      in_ready  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
`ifdef T1P_CALLSTACK_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_FETCH_OP: begin
          if (!mem_req) begin
            // Only reached straight after reset.
            mem_req  <= 1'b1;
            mem_addr <= ip;
          end else if (mem_ack) begin
            ins <= mem_rdata[7:0];
            ip  <= ip + IP_ONE;
            if (has_operand(mem_rdata[4:0])) begin
              state    <= ST_FETCH_D;
              mem_addr <= ip + IP_ONE;
            end else begin
              state   <= ST_EXEC;
              mem_req <= 1'b0;
            end
          end
        end

        ST_FETCH_D: begin
          if (mem_ack) begin
            operand <= mem_rdata;
            ip      <= ip + IP_ONE;
            mem_req <= 1'b0;
            state   <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (wr_res) rf[rd] <= alu_res;
          flags    <= flags_n;
          ip       <= next_ip;
          mem_addr <= next_ip;
          mem_req  <= 1'b1;
          state    <= ST_FETCH_OP;
          case (op)
            OP_HLT: begin
              mem_req <= 1'b0;
              halted  <= 1'b1;
              state   <= ST_HALT;
            end
            OP_MOV_R_M: begin
              mem_addr <= ea;
              mem_we   <= 1'b0;
              state    <= ST_MEM;
            end
            OP_MOV_M_R: begin
              mem_addr  <= ea;
              mem_we    <= 1'b1;
              mem_wdata <= rd_val;
              state     <= ST_MEM;
            end
            OP_IN_R: begin
              mem_req  <= 1'b0;
              in_ready <= 1'b1;
              state    <= ST_IN_WAIT;
            end
            OP_OUT_R: begin
              mem_req   <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= rd_val;
              state     <= ST_OUT_WAIT;
            end
`ifdef T1P_CALLSTACK_EN
            OP_CALL_C: begin
              if (stk_full) begin
                mem_req <= 1'b0;
                err     <= 1'b1;
                halted  <= 1'b1;
                state   <= ST_HALT;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                mem_req <= 1'b0;
                err     <= 1'b1;
                halted  <= 1'b1;
                state   <= ST_HALT;
              end
            end
`endif
            default: ;
          endcase
        end

        ST_MEM: begin
          if (mem_ack) begin
            if (!mem_we) rf[rd] <= mem_rdata;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_addr  <= ip;
            state     <= ST_FETCH_OP;
          end
        end

        ST_IN_WAIT: begin
          if (in_valid) begin
            rf[rd]   <= in_data;
            in_ready <= 1'b0;
            mem_req  <= 1'b1;
            mem_addr <= ip;
            state    <= ST_FETCH_OP;
          end
        end

        ST_OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            mem_req   <= 1'b1;
            mem_addr  <= ip;
            state     <= ST_FETCH_OP;
          end
        end

        ST_HALT: ;

        default: state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_t1p_core_hs.sv
// tb_t1p_core_hs: directed programs for t1p_core_hs with a byte memory model
// and an output scoreboard. Expected port outputs are queued per program and
// popped by a monitor whenever an out_valid/out_ready handshake occurs.
module tb_t1p_core_hs;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              halted;
  logic              err;

  logic [7:0]        mem [0:65535];
  int                ack_delay = 0;
  int                wcnt;
  int                n_vec = 0;
  int                n_bad = 0;
  logic [7:0]        exp_q [$];
  logic [7:0]        prog [$];
  logic              prev_pending = 1'b0;
  logic [ADDR_W-1:0] prev_addr;

  t1p_core_hs #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .RESET_IP    (0),
    .STACK_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halted    (halted),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Memory model: ack after ack_delay waiting cycles, read data combinational.
  assign mem_ack   = mem_req && (wcnt >= ack_delay);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or negedge rst) begin
    if (!rst)                    wcnt <= 0;
    else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                         wcnt <= 0;
  end

  always @(posedge clk) begin
    if (rst && mem_req && mem_ack && mem_we) mem[mem_addr] = mem_wdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: bus hold while waiting for ack, and output scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (prev_pending) begin
        check("req_held", mem_req, 1);
        check("addr_held", mem_addr, prev_addr);
      end
      prev_pending = mem_req && !mem_ack;
      prev_addr    = mem_addr;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_out: got 0x%0h, expected no output", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
    end else begin
      prev_pending = 1'b0;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  task automatic load(input int base);
    for (int i = 0; i < prog.size(); i++) mem[base + i] = prog[i];
  endtask

  task automatic hit_reset(input string name);
    rst = 1'b0;
    #1;
    check(name, {mem_req, mem_we, mem_addr, mem_wdata, in_ready,
                 out_data, out_valid, halted, err}, 64'd0);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic start();
    @(negedge clk);
    hit_reset("reset_outputs");
    release_reset();
  endtask

  task automatic wait_first_fetch(input string name);
    int c = 0;
    while (mem_req !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check({name, "_req"}, mem_req, 1);
    check({name, "_addr"}, mem_addr, 0);
  endtask

  task automatic finish_prog(input string name, input int bound, input logic exp_err);
    int c = 0;
    while (halted !== 1'b1 && c < bound) begin
      @(negedge clk);
      c++;
    end
    check({name, "_halted"}, halted, 1);
    repeat (3) @(negedge clk);
    check({name, "_bus_idle"}, mem_req, 0);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_err"}, err, exp_err);
    exp_q.delete();
  endtask

  task automatic load_t1();
    clear_mem();
    prog = '{8'h42, 8'h41, 8'h46, 8'hC2, 8'h51, 8'hCF, 8'h10,
             8'h62, 8'hEE, 8'h71, 8'h01};
    load('h00);
    prog = '{8'h0F, 8'h20, 8'h62, 8'hEE, 8'h71, 8'h01};
    load('h10);
    prog = '{8'h62, 8'hCC, 8'h71, 8'h01};
    load('h20);
  endtask

  task automatic load_t3(input logic [7:0] r1);
    clear_mem();
    prog = '{8'h02, 8'h01, 8'h22, r1, 8'h2A, 8'h05, 8'h8F, 8'h40,
             8'h62, 8'hB2, 8'h71, 8'hCF, 8'h50, 8'h01};
    load('h000);
    prog = '{8'h62, 8'hA1, 8'h71, 8'h01};
    load('h140);
    prog = '{8'h62, 8'hC5, 8'h71, 8'h01};
    load('h150);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;

    // ADD with carry out, output, then branch on CF=1 and ZF=0.
    load_t1();
    exp_q = '{8'h03, 8'hCC};
    start();
    wait_first_fetch("t1_fetch");
    finish_prog("t1", 200, 1'b0);

    // Same program with three wait cycles on every transfer.
    ack_delay = 3;
    load_t1();
    exp_q = '{8'h03, 8'hCC};
    start();
    finish_prog("t2", 600, 1'b0);
    ack_delay = 0;

    // CMP equal -> JF on ZF jumps to {R0,operand}=0x0140.
    load_t3(8'h05);
    exp_q = '{8'hA1};
    start();
    finish_prog("t3_eq", 200, 1'b0);

    // CMP 4 vs 5 -> falls through, then CF=1 jumps to 0x0150.
    load_t3(8'h04);
    exp_q = '{8'hB2, 8'hC5};
    start();
    finish_prog("t3_lt", 200, 1'b0);

    // R_R forms, INC/DEC wrap, illegal opcodes, store and load.
    clear_mem();
    prog = '{8'h22, 8'h10, 8'h82, 8'h30, 8'h29, 8'h04, 8'h31,
             8'hA2, 8'hFF, 8'hAC, 8'hB1, 8'hAD, 8'hB1,
             8'hC5, 8'h01, 8'hD1, 8'h14, 8'h1F,
             8'hC4, 8'h80, 8'hE3, 8'h80, 8'hF1,
             8'hE7, 8'h05, 8'hF1, 8'h01};
    load(0);
    exp_q = '{8'hE0, 8'h00, 8'hFF, 8'hE0, 8'hE0, 8'hDF};
    start();
    finish_prog("t_alu", 300, 1'b0);
    check("store_data", mem[16'h0080], 8'hE0);

    // IN stalls with in_valid low; OUT holds with out_ready low.
    clear_mem();
    prog = '{8'h50, 8'h51, 8'h01};
    load(0);
    exp_q = '{8'h5A};
    out_ready = 1'b0;
    start();
    c = 0;
    while (in_ready !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("in_ready_seen", in_ready, 1);
    repeat (10) begin
      @(negedge clk);
      check("in_ready_held", in_ready, 1);
      check("in_stall_bus", mem_req, 0);
    end
    in_data  = 8'h5A;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    c = 0;
    while (out_valid !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("out_valid_seen", out_valid, 1);
    repeat (10) begin
      @(negedge clk);
      check("out_valid_held", out_valid, 1);
      check("out_data_held", out_data, 8'h5A);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    finish_prog("t4", 100, 1'b0);

    // Reset while a fetch is waiting for ack.
    clear_mem();
    prog = '{8'h01};
    load(0);
    ack_delay = 5;
    start();
    wait_first_fetch("t5_fetch");
    @(negedge clk);
    hit_reset("rst_mid_fetch");
    release_reset();
    wait_first_fetch("t5_refetch");
    finish_prog("t5a", 100, 1'b0);
    ack_delay = 0;

    // Reset while output is pending.
    clear_mem();
    prog = '{8'h62, 8'h99, 8'h71, 8'h01};
    load(0);
    out_ready = 1'b0;
    start();
    c = 0;
    while (out_valid !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("t5b_out_pending", out_valid, 1);
    hit_reset("rst_in_out_wait");
    exp_q = '{8'h99};
    out_ready = 1'b1;
    release_reset();
    wait_first_fetch("t5b_refetch");
    finish_prog("t5b", 100, 1'b0);

`ifdef T1P_CALLSTACK_EN
    // Nine nested calls overflow an eight-entry stack.
    clear_mem();
    for (int k = 0; k < 9; k++) begin
      mem[2*k]     = 8'h12;
      mem[2*k + 1] = 8'((2*k) + 2);
    end
    prog = '{8'h62, 8'h77, 8'h71, 8'h01};
    load(18);
    start();
    finish_prog("t6_overflow", 300, 1'b1);
`else
    // CALL_C/RET are NOPs; CALL_C still consumes its operand byte.
    clear_mem();
    prog = '{8'h12, 8'h01, 8'h13, 8'h62, 8'h77, 8'h71, 8'h01};
    load(0);
    exp_q = '{8'h77};
    start();
    finish_prog("t6_nop", 200, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
